// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath:
// IR fields and status flags in, every enable and mux select out.
interface mc_control_fsm_if #(
    parameter int IO_CH = 2
);
    localparam int IOW = (IO_CH > 1) ? $clog2(IO_CH) : 1;

    logic [6:0]     op;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic           zero;
    logic           uart_done;
    logic           md_done;

    logic           pcen;
    logic           memwrite;
    logic           irwrite;
    logic           regwrite;
    logic           pcbufwrite;
    logic           iord;
    logic [1:0]     alusrca;
    logic [1:0]     alusrcb;
    logic [2:0]     regsrc;
    logic [1:0]     pcsrc;
    logic [4:0]     alucontrol;
    logic           rors;
    logic           uart_go;
    logic [IOW-1:0] io_ch;
    logic           md_start;
    logic           illegal;

    modport master (
        input  op, funct3, funct7, zero, uart_done, md_done,
        output pcen, memwrite, irwrite, regwrite, pcbufwrite, iord,
               alusrca, alusrcb, regsrc, pcsrc, alucontrol,
               rors, uart_go, io_ch, md_start, illegal
    );

    modport slave (
        output op, funct3, funct7, zero, uart_done, md_done,
        input  pcen, memwrite, irwrite, regwrite, pcbufwrite, iord,
               alusrca, alusrcb, regsrc, pcsrc, alucontrol,
               rors, uart_go, io_ch, md_start, illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM with memory wait states, IO handshake and illegal trap.
// Define CTRL_MULDIV_EN to route OP/funct7=0000001 through the multi-cycle mul/div wait path.
module mc_control_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int IO_CH    = 2
) (
    input  logic          clk,
    input  logic          rstn,
    mc_control_fsm_if.master ctrl
);
    localparam int IOW = (IO_CH > 1) ? $clog2(IO_CH) : 1;
    localparam int WCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WLAST  = WCW'(MEM_WAIT);
    localparam logic [3:0]     IO_LIM = 4'(IO_CH);

`ifdef CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IO     = 7'b0001011;

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXR, S_EXI, S_ALUWB, S_LUI, S_JAL, S_JALR, S_BRANCH, S_IO,
        S_MDSTART, S_MDWAIT, S_TRAP
    } state_t;

    state_t         state;
    state_t         dec_next;
    logic [WCW-1:0] wcnt;
    logic           wait_last;
    logic           pcwrite;
    logic           branch;
    logic           taken;

    assign wait_last = (wcnt == WLAST);

    always_comb begin
        dec_next = S_TRAP;
        case (ctrl.op)
            OP_LOAD, OP_STORE: dec_next = S_MEMADR;
            OP_REG: begin
                if (ctrl.funct7 == 7'b0000000 || ctrl.funct7 == 7'b0100000)
                    dec_next = S_EXR;
                else if (MD_EN && ctrl.funct7 == 7'b0000001)
                    dec_next = S_MDSTART;
            end
            OP_IMM:    dec_next = S_EXI;
            OP_LUI:    dec_next = S_LUI;
            OP_AUIPC:  dec_next = S_ALUWB;
            OP_JAL:    dec_next = S_JAL;
            OP_JALR:   dec_next = S_JALR;
            OP_BRANCH: if (ctrl.funct3[2:1] != 2'b01) dec_next = S_BRANCH;
            OP_IO:     if ({1'b0, ctrl.funct3} < IO_LIM) dec_next = S_IO;
            default:   dec_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_RST;
            wcnt  <= '0;
        end else begin
            case (state)
                S_RST: state <= S_FETCH;
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    // one counter serves all three memory states; it is cleared on exit
                    if (wait_last) begin
                        wcnt <= '0;
                        if (state == S_FETCH)      state <= S_DECODE;
                        else if (state == S_MEMRD) state <= S_MEMWB;
                        else                       state <= S_FETCH;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DECODE:     state <= dec_next;
                S_MEMADR:     state <= (ctrl.op == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_EXR, S_EXI: state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_LUI, S_JAL, S_JALR, S_BRANCH:
                              state <= S_FETCH;
                S_IO:         if (ctrl.uart_done) state <= S_FETCH;
                S_MDSTART:    state <= S_MDWAIT;
                S_MDWAIT:     if (ctrl.md_done) state <= S_FETCH;
                S_TRAP:       state <= S_TRAP;
                default:      state <= S_RST;
            endcase
        end
    end

    always_comb begin
        pcwrite          = 1'b0;
        branch           = 1'b0;
        ctrl.memwrite    = 1'b0;
        ctrl.irwrite     = 1'b0;
        ctrl.regwrite    = 1'b0;
        ctrl.pcbufwrite  = 1'b0;
        ctrl.iord        = 1'b0;
        ctrl.alusrca     = 2'b00;
        ctrl.alusrcb     = 2'b00;
        ctrl.regsrc      = 3'b000;
        ctrl.pcsrc       = 2'b00;
        ctrl.alucontrol  = 5'b00000;
        ctrl.rors        = 1'b0;
        ctrl.uart_go     = 1'b0;
        ctrl.io_ch       = '0;
        ctrl.md_start    = 1'b0;
        ctrl.illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb = 2'b01;
                if (wait_last) begin
                    pcwrite         = 1'b1;
                    ctrl.irwrite    = 1'b1;
                    ctrl.pcbufwrite = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl.alusrca = 2'b10;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMADR: begin
                ctrl.alusrca = 2'b01;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.regsrc   = 3'b001;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXR: begin
                ctrl.alusrca    = 2'b01;
                ctrl.alucontrol = {1'b0, ctrl.funct7[5], ctrl.funct3};
            end
            S_EXI: begin
                ctrl.alusrca    = 2'b01;
                ctrl.alusrcb    = 2'b10;
                // only SRAI takes the alternate bit from the immediate's funct7 field
                ctrl.alucontrol = {1'b0, (ctrl.funct3 == 3'b101) & ctrl.funct7[5], ctrl.funct3};
            end
            S_ALUWB: ctrl.regwrite = 1'b1;
            S_LUI: begin
                ctrl.regsrc   = 3'b011;
                ctrl.regwrite = 1'b1;
            end
            S_JAL: begin
                ctrl.regsrc   = 3'b010;
                ctrl.regwrite = 1'b1;
                ctrl.pcsrc    = 2'b01;
                pcwrite       = 1'b1;
            end
            S_JALR: begin
                ctrl.alusrca  = 2'b01;
                ctrl.alusrcb  = 2'b10;
                ctrl.pcsrc    = 2'b10;
                pcwrite       = 1'b1;
                ctrl.regsrc   = 3'b010;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 2'b01;
                ctrl.alucontrol = {2'b10, ctrl.funct3};
                ctrl.pcsrc      = 2'b01;
                branch          = 1'b1;
            end
            S_IO: begin
                ctrl.uart_go = 1'b1;
                ctrl.rors    = ctrl.funct7[0];
                ctrl.io_ch   = ctrl.funct3[IOW-1:0];
                if (ctrl.uart_done && !ctrl.funct7[0]) begin
                    ctrl.regsrc   = 3'b100;
                    ctrl.regwrite = 1'b1;
                end
            end
            S_MDSTART: begin
                ctrl.md_start   = 1'b1;
                ctrl.alusrca    = 2'b01;
                ctrl.alucontrol = {2'b11, ctrl.funct3};
            end
            S_MDWAIT: begin
                ctrl.alusrca    = 2'b01;
                ctrl.alucontrol = {2'b11, ctrl.funct3};
                if (ctrl.md_done) begin
                    ctrl.regsrc   = 3'b101;
                    ctrl.regwrite = 1'b1;
                end
            end
            S_TRAP:  ctrl.illegal = 1'b1;
            default: ;
        endcase
    end

    assign taken     = branch & (ctrl.zero ^ ctrl.funct3[0] ^ ctrl.funct3[2]);
    assign ctrl.pcen = pcwrite | taken;
endmodule
